matrix_loader: RTL and testbench



---
 rtl/matrix_loader_if.sv | 9 +
 rtl/matrix_loader.sv | 162 ++++++++++++++++
 tb/tb_matrix_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// Byte-stream valid/ready channel carrying operand bytes into the matrix loader.
interface matrix_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/matrix_loader.sv
// Fills 3x3 A/B operand registers from a byte stream, fires the multiplier and waits for Done.
// Optional feature: define MATRIX_LOADER_CHECKSUM_EN to require a mod-256 checksum byte per frame.
module matrix_loader #(
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           Reset,
  matrix_loader_if.slave s,
  output logic [7:0]     A00, A01, A02, A10, A11, A12, A20, A21, A22,
  output logic [7:0]     B00, B01, B02, B10, B11, B12, B20, B21, B22,
  output logic           Load,
  input  logic           Done,
  output logic           busy,
  output logic           frame_done,
  output logic           err
);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FILL_A,
    FILL_B,
`ifdef MATRIX_LOADER_CHECKSUM_EN
    CHECK,
`endif
    FIRE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q;
  logic [7:0]    a_q [9];
  logic [7:0]    b_q [9];
  logic [TW-1:0] tcnt_q;
  logic          ready, xfer, fill, last_byte, tmo;
  logic          done_evt, tmo_evt, ck_err;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  // Input is held off for the cycle carrying frame_done/err so the next frame starts cleanly after it.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      FILL_A, FILL_B: ready = 1'b1;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      CHECK:          ready = 1'b1;
`endif
      default:        ready = 1'b0;
    endcase
    ready = ready && Reset && !frame_done && !err;
  end

  assign s.in_ready = ready;
  assign xfer       = s.in_valid && ready;
  assign fill       = (state_q == FILL_A) || (state_q == FILL_B);
  assign last_byte  = (idx_q == 4'd8);
  assign tmo        = (tcnt_q == TW'(WAIT_TIMEOUT - 1));

  // NOTE: non-blocking assignments in clocked blocks, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!Reset) state_q <= FILL_A;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    ck_err   = 1'b0;
    case (state_q)
      FILL_A: if (xfer && last_byte) state_d = FILL_B;
      FILL_B: begin
        if (xfer && last_byte) begin
`ifdef MATRIX_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = FIRE;
`endif
        end
      end
`ifdef MATRIX_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (s.in_data == sum_q) begin
            state_d = FIRE;
          end else begin
            state_d = FILL_A;
            ck_err  = 1'b1;
          end
        end
      end
`endif
      FIRE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!Done) begin
          state_d = WAIT_DONE;
        end else if (tmo) begin
          state_d = FILL_A;
          tmo_evt = 1'b1;
        end
      end
      WAIT_DONE: begin
        // Completion wins over a timeout landing on the same cycle, so the two pulses never coincide.
        if (Done) begin
          state_d  = FILL_A;
          done_evt = 1'b1;
        end else if (tmo) begin
          state_d = FILL_A;
          tmo_evt = 1'b1;
        end
      end
      default: state_d = FILL_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      idx_q      <= 4'd0;
      tcnt_q     <= '0;
      Load       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      // NOTE: operand arrays are reset explicitly; they drive the multiplier and must read zero.
      for (int i = 0; i < 9; i++) begin
        a_q[i] <= 8'd0;
        b_q[i] <= 8'd0;
      end
`ifdef MATRIX_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      Load       <= (state_d == FIRE);
      frame_done <= done_evt;
      err        <= tmo_evt | ck_err;

      if (state_q == WAIT_BUSY || state_q == WAIT_DONE) tcnt_q <= tcnt_q + TW'(1);
      else                                              tcnt_q <= '0;

      if (xfer && fill) begin
        if (state_q == FILL_A) a_q[idx_q] <= s.in_data;
        else                   b_q[idx_q] <= s.in_data;
        idx_q <= last_byte ? 4'd0 : idx_q + 4'd1;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        sum_q <= (state_q == FILL_A && idx_q == 4'd0) ? s.in_data : sum_q + s.in_data;
`endif
      end

      if (done_evt || tmo_evt || ck_err)                          busy <= 1'b0;
      else if (xfer && state_q == FILL_A && idx_q == 4'd0)        busy <= 1'b1;
    end
  end

  assign A00 = a_q[0];  assign A01 = a_q[1];  assign A02 = a_q[2];
  assign A10 = a_q[3];  assign A11 = a_q[4];  assign A12 = a_q[5];
  assign A20 = a_q[6];  assign A21 = a_q[7];  assign A22 = a_q[8];
  assign B00 = b_q[0];  assign B01 = b_q[1];  assign B02 = b_q[2];
  assign B10 = b_q[3];  assign B11 = b_q[4];  assign B12 = b_q[5];
  assign B20 = b_q[6];  assign B21 = b_q[7];  assign B22 = b_q[8];
endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: operand scoreboard checked at each Load, plus timing checks.
module tb_matrix_loader;
  localparam int WAIT_TIMEOUT = 64;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  localparam int FRAME_CYC = 19;
`else
  localparam int FRAME_CYC = 18;
`endif

  logic clk   = 1'b0;
  logic Reset = 1'b0;
  logic Done  = 1'b1;
  logic Load, busy, frame_done, err;
  logic [7:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
  logic [7:0] B00, B01, B02, B10, B11, B12, B20, B21, B22;

  matrix_loader_if sif ();

  matrix_loader #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .Reset(Reset), .s(sif),
    .A00(A00), .A01(A01), .A02(A02), .A10(A10), .A11(A11), .A12(A12),
    .A20(A20), .A21(A21), .A22(A22),
    .B00(B00), .B01(B01), .B02(B02), .B10(B10), .B11(B11), .B12(B12),
    .B20(B20), .B21(B21), .B22(B22),
    .Load(Load), .Done(Done), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int load_cnt = 0, fd_cnt = 0, err_cnt = 0;
  int load_cyc = 0, fd_cyc = 0, err_cyc = 0, done_rise_cyc = 0;
  bit done_auto = 1'b1;
  logic [7:0] exp_q [$];
  logic [7:0] sb_exp;
  logic [7:0] ops [18];

  always_comb begin
    ops[0]  = A00; ops[1]  = A01; ops[2]  = A02; ops[3]  = A10; ops[4]  = A11; ops[5]  = A12;
    ops[6]  = A20; ops[7]  = A21; ops[8]  = A22; ops[9]  = B00; ops[10] = B01; ops[11] = B02;
    ops[12] = B10; ops[13] = B11; ops[14] = B12; ops[15] = B20; ops[16] = B21; ops[17] = B22;
  end

  function automatic logic [143:0] pack_ops();
    logic [143:0] p = '0;
    for (int i = 0; i < 18; i++) p[i*8 +: 8] = ops[i];
    return p;
  endfunction

  function automatic logic [143:0] pack_arr(input logic [7:0] f [18]);
    logic [143:0] p = '0;
    for (int i = 0; i < 18; i++) p[i*8 +: 8] = f[i];
    return p;
  endfunction

  // Scoreboard pop at every Load, plus per-pulse event bookkeeping.
  always @(negedge clk) begin
    if (Load === 1'b1) begin
      load_cnt++;
      load_cyc = cyc;
      total++;
      if (busy !== 1'b1) $display("FAIL busy_at_load: got %b want 1", busy);
      else passed++;
      if (exp_q.size() < 18) begin
        total++;
        $display("FAIL scoreboard_underflow: got %0d entries want 18", exp_q.size());
      end else begin
        for (int i = 0; i < 18; i++) begin
          sb_exp = exp_q.pop_front();
          total++;
          if (ops[i] !== sb_exp) $display("FAIL operand_at_load[%0d]: got %02h want %02h", i, ops[i], sb_exp);
          else passed++;
        end
      end
    end
    if (frame_done === 1'b1) begin fd_cnt++;  fd_cyc  = cyc; end
    if (err === 1'b1)        begin err_cnt++; err_cyc = cyc; end
    if (frame_done === 1'b1 || err === 1'b1) begin
      total++;
      if (frame_done === 1'b1 && err === 1'b1) $display("FAIL done_err_overlap: got both high want one");
      else passed++;
    end
  end

  // Multiplier model: drops Done the cycle after sampling Load, keeps it low for 7 cycles.
  initial forever begin
    @(negedge clk);
    if (Load === 1'b1 && done_auto) begin
      @(posedge clk); #1 Done = 1'b0;
      repeat (7) @(posedge clk);
      #1 Done = 1'b1;
      done_rise_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, output int acc_cyc);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      step();
      sif.in_valid = 1'b0;
      sif.in_data  = 8'($urandom);
    end
    step();
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    while (sif.in_ready !== 1'b1 && n < 300) begin step(); n++; end
    if (sif.in_ready !== 1'b1) begin
      total++;
      $display("FAIL send_timeout: in_ready got %b want 1", sif.in_ready);
    end
    acc_cyc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] f [18], input int gap, input bit bad_ck, output int c0);
    int c;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [7:0] sum = 8'd0;
`endif
    if (!bad_ck) for (int i = 0; i < 18; i++) exp_q.push_back(f[i]);
    for (int i = 0; i < 18; i++) begin
      send_byte(f[i], gap, c);
      if (i == 0) c0 = c;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      sum = sum + f[i];
`endif
    end
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(bad_ck ? 8'h00 : sum, gap, c);
`endif
    step();
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_end(input int start, input int budget);
    int n = 0;
    while (fd_cnt + err_cnt == start && n < budget) begin step(); n++; end
    if (fd_cnt + err_cnt == start) begin
      total++;
      $display("FAIL wait_end_timeout: got no frame_done/err within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (sif.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", sif.in_ready); else passed++;
    total++; if (pack_ops() !== 144'd0) $display("FAIL reset_operands: got %h want 0", pack_ops()); else passed++;
    total++; if (Load !== 1'b0) $display("FAIL reset_load: got %b want 0", Load); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({frame_done, err} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {frame_done, err}); else passed++;
    Reset = 1'b1;
    sif.in_valid = 1'b0;
    step();
    total++; if (sif.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", sif.in_ready); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] f [18];
    int c0, ld0, fd0, er0;
    for (int i = 0; i < 18; i++) f[i] = 8'(i + 1);
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f, 0, 1'b0, c0);
    wait_end(fd0 + er0, 200);
    total++; if (load_cnt - ld0 !== 1) $display("FAIL basic_load_count: got %0d want 1", load_cnt - ld0); else passed++;
    total++; if (load_cyc !== c0 + FRAME_CYC) $display("FAIL basic_load_cycle: got %0d want %0d", load_cyc, c0 + FRAME_CYC); else passed++;
    total++; if (fd_cnt - fd0 !== 1 || err_cnt !== er0) $display("FAIL basic_outcome: got fd=%0d err=%0d want fd=1 err=0", fd_cnt - fd0, err_cnt - er0); else passed++;
    total++; if (fd_cyc !== done_rise_cyc + 1) $display("FAIL basic_fd_cycle: got %0d want %0d", fd_cyc, done_rise_cyc + 1); else passed++;
    total++; if (sif.in_ready !== 1'b0) $display("FAIL basic_ready_at_fd: got %b want 0", sif.in_ready); else passed++;
    total++; if (A00 !== 8'd1)  $display("FAIL basic_A00: got %0d want 1", A00);  else passed++;
    total++; if (A22 !== 8'd9)  $display("FAIL basic_A22: got %0d want 9", A22);  else passed++;
    total++; if (B00 !== 8'd10) $display("FAIL basic_B00: got %0d want 10", B00); else passed++;
    total++; if (B22 !== 8'd18) $display("FAIL basic_B22: got %0d want 18", B22); else passed++;
    total++; if (pack_ops() !== pack_arr(f)) $display("FAIL basic_hold: got %h want %h", pack_ops(), pack_arr(f)); else passed++;
    step();
    total++; if (sif.in_ready !== 1'b1) $display("FAIL basic_ready_after_fd: got %b want 1", sif.in_ready); else passed++;
    total++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL basic_idle: got busy=%b fd=%b want 0 0", busy, frame_done); else passed++;
  endtask

  task automatic test_gapped();
    logic [7:0] f [18];
    int c0, ld0, fd0, er0;
    for (int i = 0; i < 18; i++) f[i] = 8'(8'h20 + 3 * i);
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f, 2, 1'b0, c0);
    total++; if (load_cyc !== c0 + 3 * (FRAME_CYC - 1) + 1) $display("FAIL gapped_load_cycle: got %0d want %0d", load_cyc, c0 + 3 * (FRAME_CYC - 1) + 1); else passed++;
    sif.in_valid = 1'b1;
    sif.in_data  = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      total++; if (sif.in_ready !== 1'b0) $display("FAIL gapped_ready_in_wait[%0d]: got %b want 0", k, sif.in_ready); else passed++;
      if (k < 3) step();
    end
    sif.in_valid = 1'b0;
    wait_end(fd0 + er0, 200);
    total++; if (load_cnt - ld0 !== 1 || fd_cnt - fd0 !== 1) $display("FAIL gapped_counts: got load=%0d fd=%0d want 1 1", load_cnt - ld0, fd_cnt - fd0); else passed++;
    total++; if (pack_ops() !== pack_arr(f)) $display("FAIL gapped_hold: got %h want %h", pack_ops(), pack_arr(f)); else passed++;
    step();
  endtask

  task automatic test_timeout();
    logic [7:0] f [18];
    int c0, ld0, fd0, er0;
    for (int i = 0; i < 18; i++) f[i] = 8'(8'h40 + i);
    done_auto = 1'b0;
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f, 0, 1'b0, c0);
    wait_end(fd0 + er0, 300);
    total++; if (err_cnt - er0 !== 1 || fd_cnt !== fd0) $display("FAIL timeout_outcome: got err=%0d fd=%0d want err=1 fd=0", err_cnt - er0, fd_cnt - fd0); else passed++;
    total++; if (load_cnt - ld0 !== 1) $display("FAIL timeout_load_count: got %0d want 1", load_cnt - ld0); else passed++;
    // FIRE cycle, then WAIT_TIMEOUT wait cycles, then the registered err pulse.
    total++; if (err_cyc - load_cyc !== WAIT_TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", err_cyc - load_cyc, WAIT_TIMEOUT + 1); else passed++;
    total++; if (sif.in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL timeout_at_err: got ready=%b busy=%b want 0 0", sif.in_ready, busy); else passed++;
    total++; if (pack_ops() !== pack_arr(f)) $display("FAIL timeout_retain: got %h want %h", pack_ops(), pack_arr(f)); else passed++;
    step();
    total++; if (sif.in_ready !== 1'b1 || err !== 1'b0) $display("FAIL timeout_after: got ready=%b err=%b want 1 0", sif.in_ready, err); else passed++;
    done_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] f [18];
    int c, c0, ld0, fd0, er0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 0, c);
    step();
    Reset = 1'b0;
    sif.in_valid = 1'b0;
    step();
    total++; if (pack_ops() !== 144'd0 || busy !== 1'b0) $display("FAIL midreset_clear: got ops=%h busy=%b want 0 0", pack_ops(), busy); else passed++;
    total++; if (sif.in_ready !== 1'b0) $display("FAIL midreset_ready: got %b want 0", sif.in_ready); else passed++;
    Reset = 1'b1;
    for (int i = 0; i < 18; i++) f[i] = 8'hAA;
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f, 0, 1'b0, c0);
    wait_end(fd0 + er0, 200);
    total++; if (load_cnt - ld0 !== 1) $display("FAIL midreset_load_count: got %0d want 1", load_cnt - ld0); else passed++;
    total++; if (pack_ops() !== pack_arr(f)) $display("FAIL midreset_ops: got %h want %h", pack_ops(), pack_arr(f)); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1 [18];
    logic [7:0] f2 [18];
    int c0, c0b, ld0, fd0, er0;
    for (int i = 0; i < 18; i++) begin
      f1[i] = 8'(8'h80 + 5 * i);
      f2[i] = 8'(8'hF0 - 7 * i);
    end
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f1, 0, 1'b0, c0);
    send_frame(f2, 0, 1'b0, c0b);
    total++; if (fd_cnt - fd0 !== 1) $display("FAIL b2b_first_done: got %0d want 1", fd_cnt - fd0); else passed++;
    total++; if (c0b !== fd_cyc + 1) $display("FAIL b2b_restart_cycle: got %0d want %0d", c0b, fd_cyc + 1); else passed++;
    wait_end(fd_cnt + err_cnt, 200);
    total++; if (load_cnt - ld0 !== 2 || fd_cnt - fd0 !== 2 || err_cnt !== er0) $display("FAIL b2b_counts: got load=%0d fd=%0d err=%0d want 2 2 0", load_cnt - ld0, fd_cnt - fd0, err_cnt - er0); else passed++;
    total++; if (pack_ops() !== pack_arr(f2)) $display("FAIL b2b_ops: got %h want %h", pack_ops(), pack_arr(f2)); else passed++;
    step();
  endtask

`ifdef MATRIX_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] f [18];
    int c0, ld0, fd0, er0;
    for (int i = 0; i < 18; i++) f[i] = 8'(i + 1);
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f, 0, 1'b0, c0);
    wait_end(fd0 + er0, 200);
    total++; if (load_cnt - ld0 !== 1 || fd_cnt - fd0 !== 1) $display("FAIL ck_good: got load=%0d fd=%0d want 1 1", load_cnt - ld0, fd_cnt - fd0); else passed++;
    step();
    ld0 = load_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_frame(f, 0, 1'b1, c0);
    wait_end(fd0 + er0, 50);
    total++; if (err_cnt - er0 !== 1 || err_cyc !== c0 + 19) $display("FAIL ck_bad_err: got n=%0d cyc=%0d want 1 %0d", err_cnt - er0, err_cyc, c0 + 19); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ck_bad_busy: got %b want 0", busy); else passed++;
    step();
    total++; if (sif.in_ready !== 1'b1) $display("FAIL ck_bad_ready: got %b want 1", sif.in_ready); else passed++;
    step(); step(); step();
    total++; if (load_cnt !== ld0) $display("FAIL ck_bad_no_load: got %0d loads want 0", load_cnt - ld0); else passed++;
  endtask
`endif

  initial begin
    sif.in_valid = 1'b1;
    sif.in_data  = 8'h5A;
    test_reset();
    test_basic();
    test_gapped();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef MATRIX_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
